// File: rtl/array_multiplier_mac.sv
// Multi-lane pipelined multiplier with per-beat signed/unsigned mode,
// valid/ready backpressure and an optional accumulator of the lane-product sum.

// Single lane: exact W x W product, signed or unsigned, kept to 2W bits.
module array_multiplier_mac_lane #(
    parameter int W = 16
) (
    input  logic           i_signed,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_z
);
    logic signed [2*W-1:0] w_a;
    logic signed [2*W-1:0] w_b;
    logic signed [2*W-1:0] w_p;

    // Extending both operands to 2W bits makes one multiplier serve both modes;
    // the 2W-bit truncation is exact for every W x W product, including -2^(W-1)^2.
    assign w_a = {{W{i_signed & i_a[W-1]}}, i_a};
    assign w_b = {{W{i_signed & i_b[W-1]}}, i_b};
    assign w_p = w_a * w_b;
    assign o_z = w_p;
endmodule

module array_multiplier_mac #(
    parameter int DATAWIDTH           = 16,
    parameter int NUM_LANES           = 2,
    parameter int NUM_PIPELINE_STAGES = 4,
    parameter int ACC_WIDTH           = 2*DATAWIDTH+8,
    parameter int INSTANCE_ID         = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    output logic                             i_ready,
    input  logic                             i_signed,
    input  logic                             i_acc_en,
    input  logic                             i_acc_clear,
    input  logic [NUM_LANES*DATAWIDTH-1:0]   A,
    input  logic [NUM_LANES*DATAWIDTH-1:0]   B,
    output logic                             o_valid,
    input  logic                             o_ready,
    output logic [NUM_LANES*2*DATAWIDTH-1:0] Z_final,
    output logic [ACC_WIDTH-1:0]             o_acc,
    output logic                             o_overflow
);
    localparam int P  = NUM_PIPELINE_STAGES;
    localparam int ZW = 2*DATAWIDTH;

    logic [NUM_LANES-1:0][ZW-1:0]        w_prod;
    logic                                w_adv;

    logic [P-1:0]                        r_vld_pipe;
    logic [P-1:0]                        r_sgn;
    logic [P-1:0]                        r_acc_en;
    logic [P-1:0]                        r_acc_clr;
    logic [P-1:0][NUM_LANES-1:0][ZW-1:0] r_z;

    logic [ACC_WIDTH-1:0]                r_acc;
    logic                                r_ovf;

    logic [ACC_WIDTH-1:0]                w_sum;
    logic [ACC_WIDTH-1:0]                w_base;
    logic [ACC_WIDTH:0]                  w_add;
    logic                                w_sovf;
    logic                                w_ovf;

    // Products are formed at the input; the stage chain carries them to the output
    // so the multiplier can be retimed across the stages.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        array_multiplier_mac_lane #(.W(DATAWIDTH)) u_lane (
            .i_signed (i_signed),
            .i_a      (A[k*DATAWIDTH +: DATAWIDTH]),
            .i_b      (B[k*DATAWIDTH +: DATAWIDTH]),
            .o_z      (w_prod[k])
        );
    end

    // Whole pipeline moves together whenever the output slot is free or draining.
    assign w_adv   = !o_valid | o_ready;
    assign i_ready = w_adv;
    assign o_valid = r_vld_pipe[P-1];
    assign Z_final = r_z[P-1];
    assign o_acc   = r_acc;
    assign o_overflow = r_ovf;

    // Stage shift: valids always move; data/tags only load from a valid source,
    // so Z_final keeps the last delivered product across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
            r_sgn      <= '0;
            r_acc_en   <= '0;
            r_acc_clr  <= '0;
            r_z        <= '0;
        end else if (w_adv) begin
            for (int k = P-1; k >= 1; k--) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                if (r_vld_pipe[k-1]) begin
                    r_z[k]       <= r_z[k-1];
                    r_sgn[k]     <= r_sgn[k-1];
                    r_acc_en[k]  <= r_acc_en[k-1];
                    r_acc_clr[k] <= r_acc_clr[k-1];
                end
            end
            r_vld_pipe[0] <= i_valid;
            if (i_valid) begin
                r_z[0]       <= w_prod;
                r_sgn[0]     <= i_signed;
                r_acc_en[0]  <= i_acc_en;
                r_acc_clr[0] <= i_acc_clear;
            end
        end
    end

    // Lane-sum of the output beat, accumulator add and its overflow condition.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_sum = w_sum + {{(ACC_WIDTH-ZW){r_sgn[P-1] & r_z[P-1][k][ZW-1]}}, r_z[P-1][k]};
        end
        w_base = r_acc_clr[P-1] ? '0 : r_acc;
        w_add  = {1'b0, w_base} + {1'b0, w_sum};
        w_sovf = (w_base[ACC_WIDTH-1] == w_sum[ACC_WIDTH-1]) &&
                 (w_add[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
        w_ovf  = r_sgn[P-1] ? w_sovf : w_add[ACC_WIDTH];
    end

    // Accumulate only on an output transfer of an acc_en beat; clear restarts the sticky flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (o_valid && o_ready && r_acc_en[P-1]) begin
            r_acc <= w_add[ACC_WIDTH-1:0];
            r_ovf <= (r_acc_clr[P-1] ? 1'b0 : r_ovf) | w_ovf;
        end
    end
endmodule

// File: tb/tb_array_multiplier_mac.sv
// Directed bench for array_multiplier_mac (W=16, L=2, P=4, ACC_WIDTH=40).
module tb_array_multiplier_mac;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, i_signed, i_acc_en, i_acc_clear;
    logic [31:0] A, B;
    logic        o_valid, o_ready;
    logic [63:0] Z_final;
    logic [39:0] o_acc;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;

    array_multiplier_mac #(
        .DATAWIDTH(16), .NUM_LANES(2), .NUM_PIPELINE_STAGES(4), .ACC_WIDTH(40), .INSTANCE_ID(0)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_signed(i_signed),
        .i_acc_en(i_acc_en), .i_acc_clear(i_acc_clear), .A(A), .B(B),
        .o_valid(o_valid), .o_ready(o_ready), .Z_final(Z_final),
        .o_acc(o_acc), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated beat with o_ready=1; returns the delivered product once it has transferred.
    task automatic run_beat(input logic sg, input logic en, input logic clr,
                            input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] b0, input logic [15:0] b1,
                            output logic [63:0] z);
        logic got;
        got = 1'b0;
        z = '0;
        @(negedge clk);
        i_valid = 1'b1; i_signed = sg; i_acc_en = en; i_acc_clear = clr;
        A = {a1, a0}; B = {b1, b0};
        @(posedge clk);
        #1 i_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (o_valid) begin got = 1'b1; break; end
        end
        if (!got) chk("beat_timeout", {63'd0, got}, 64'd1);
        z = Z_final;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] z;
    logic [63:0] exp_q[$];
    logic [63:0] z_prev, e;
    logic        stall_prev;
    int          sent, got_n;
    logic [40:0] acc_m;
    logic        ovf_m;
    logic [40:0] s_ff;

    initial begin
        rst = 1'b0; i_valid = 0; i_signed = 0; i_acc_en = 0; i_acc_clear = 0;
        A = '0; B = '0; o_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ovalid", {63'd0, o_valid}, 64'd0);
        chk("rst_z", Z_final, 64'd0);
        chk("rst_acc", {24'd0, o_acc}, 64'd0);
        chk("rst_ovf", {63'd0, o_overflow}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_iready", {63'd0, i_ready}, 64'd1);

        // latency: accepted at edge e0, valid only after e3
        i_valid = 1'b1; A = {16'd5, 16'd3}; B = {16'd11, 16'd7};
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) i_valid = 1'b0;
            chk("lat_ovalid", {63'd0, o_valid}, (k == 3) ? 64'd1 : 64'd0);
            if (k == 3) chk("lat_z", Z_final, {32'd55, 32'd21});
        end

        // signed and unsigned corners
        run_beat(1, 0, 0, 16'h8000, 16'hFFFD, 16'h8000, 16'd5, z);
        chk("sgn_z0", {32'd0, z[31:0]}, 64'h4000_0000);
        chk("sgn_z1", {32'd0, z[63:32]}, 64'hFFFF_FFF1);
        run_beat(0, 0, 0, 16'h8000, 16'hFFFD, 16'h8000, 16'd5, z);
        chk("uns_z0", {32'd0, z[31:0]}, 64'h4000_0000);
        chk("uns_z1", {32'd0, z[63:32]}, 64'h0004_FFF1);
        chk("noacc_acc", {24'd0, o_acc}, 64'd0);

        // backpressure: 8 beats, o_ready low for 5 cycles mid-stream
        sent = 0; got_n = 0; stall_prev = 1'b0; z_prev = '0;
        i_acc_en = 0; i_acc_clear = 0; i_signed = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            o_ready = !(c >= 6 && c < 11);
            if (sent < 8) begin
                i_valid = 1'b1;
                A = {16'(sent + 10), 16'(sent + 1)};
                B = {16'd100, 16'(sent + 3)};
            end else i_valid = 1'b0;
            #1;
            if (o_valid && !o_ready) begin
                chk("bp_iready", {63'd0, i_ready}, 64'd0);
                if (stall_prev) chk("bp_hold", Z_final, z_prev);
            end
            stall_prev = o_valid && !o_ready;
            z_prev = Z_final;
            if (o_valid && o_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                chk("bp_data", Z_final, e);
                got_n++;
            end
            if (i_valid && i_ready) begin
                exp_q.push_back({32'((sent + 10) * 100), 32'((sent + 1) * (sent + 3))});
                sent++;
            end
        end
        o_ready = 1'b1; i_valid = 1'b0;
        chk("bp_count", 64'(got_n), 64'd8);
        chk("bp_left", 64'(exp_q.size()), 64'd0);

        // MAC
        run_beat(0, 1, 1, 16'd2, 16'd4, 16'd3, 16'd5, z);
        chk("mac_26", {24'd0, o_acc}, 64'd26);
        run_beat(0, 1, 0, 16'd1, 16'd1, 16'd1, 16'd1, z);
        chk("mac_28", {24'd0, o_acc}, 64'd28);
        run_beat(0, 0, 0, 16'd9, 16'd9, 16'd9, 16'd9, z);
        chk("mac_hold", {24'd0, o_acc}, 64'd28);
        run_beat(0, 0, 1, 16'd9, 16'd9, 16'd9, 16'd9, z);
        chk("mac_clr_noen", {24'd0, o_acc}, 64'd28);
        run_beat(1, 1, 1, 16'hFFFD, 16'd1, 16'd5, 16'd1, z);
        chk("mac_sgn", {24'd0, o_acc}, 64'h00FF_FFFF_FFF2);
        chk("mac_sgn_ovf", {63'd0, o_overflow}, 64'd0);

        // unsigned carry-out overflow, done twice: clear after the first, async reset after the second
        s_ff = 41'h0_FFFE_0001 * 2;
        for (int rep = 0; rep < 2; rep++) begin
            acc_m = '0; ovf_m = 1'b0;
            for (int n = 1; n <= 130; n++) begin
                run_beat(0, 1, n == 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, z);
                acc_m = ((n == 1) ? 41'd0 : {1'b0, acc_m[39:0]}) + s_ff;
                ovf_m = ((n == 1) ? 1'b0 : ovf_m) | acc_m[40];
                if (n == 128) chk("ovf_128", {63'd0, o_overflow}, 64'd0);
                if (n == 129) begin
                    chk("ovf_129", {63'd0, o_overflow}, 64'd1);
                    chk("ovf_acc", {24'd0, o_acc}, {24'd0, acc_m[39:0]});
                end
                if (n == 130) chk("ovf_sticky", {63'd0, o_overflow}, {63'd0, ovf_m});
            end
            if (rep == 0) begin
                run_beat(0, 1, 1, 16'd1, 16'd1, 16'd1, 16'd1, z);
                chk("ovf_clear", {63'd0, o_overflow}, 64'd0);
                chk("ovf_clear_acc", {24'd0, o_acc}, 64'd2);
            end
        end

        // async reset with 3 beats in flight
        @(negedge clk);
        i_valid = 1'b1; i_acc_en = 1'b1; i_acc_clear = 1'b0; i_signed = 1'b0;
        A = {16'd7, 16'd7}; B = {16'd7, 16'd7};
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_ovalid", {63'd0, o_valid}, 64'd0);
        chk("arst_acc", {24'd0, o_acc}, 64'd0);
        chk("arst_ovf", {63'd0, o_overflow}, 64'd0);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_iready", {63'd0, i_ready}, 64'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("arst_nobeat", {63'd0, o_valid}, 64'd0);
        end
        chk("arst_acc_end", {24'd0, o_acc}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
